// File: rtl/ysyx_24080006_pkg.sv
// Shared pipeline types for the ysyx_24080006 core: stage payload, retire-queue
// entry, write-port bundle and the retire-time decode.
package ysyx_24080006_pkg;

   localparam logic [11:0] CSR_MCAUSE = 12'h342;

   typedef struct packed {
      logic        valid;
      logic        wb;
      logic        csr_we;
      logic        ecall;
      logic [4:0]  rd_addr;
      logic [31:0] alu_res;
      logic [31:0] csr_wdata;
      logic [11:0] csr_addr;
      logic [31:0] dnpc;
      logic        jump;
      logic        branch;
   } stage_t;

   typedef struct packed {
      logic        wb;
      logic        csr_we;
      logic        ecall;
      logic [4:0]  rd_addr;
      logic [31:0] alu_res;
      logic [31:0] csr_wdata;
      logic [11:0] csr_addr;
      logic [31:0] dnpc;
      logic        jump;
      logic        branch;
   } wb_entry_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] wdata;
      logic        we;
      logic        csr_we;
      logic [11:0] csr_waddr;
      logic [31:0] csr_wdata;
   } wb_write_t;

   // Priority wb > csr_we > ecall; a write to x0 leaves the whole RF side at 0.
   function automatic wb_write_t wb_decode(input wb_entry_t e, input logic [31:0] ecall_cause);
      wb_write_t w;
      w = '0;
      if (e.wb) begin
         if (e.rd_addr != 5'd0) begin
            w.rd    = e.rd_addr;
            w.wdata = e.alu_res;
            w.we    = 1'b1;
         end
      end else if (e.csr_we) begin
         if (e.rd_addr != 5'd0) begin
            w.rd    = e.rd_addr;
            w.wdata = e.csr_wdata;
            w.we    = 1'b1;
         end
         w.csr_we    = 1'b1;
         w.csr_waddr = e.csr_addr;
         w.csr_wdata = e.alu_res;
      end else if (e.ecall) begin
         w.csr_we    = 1'b1;
         w.csr_waddr = CSR_MCAUSE;
         w.csr_wdata = ecall_cause;
      end
      return w;
   endfunction

endpackage

// File: rtl/ysyx_24080006_fifo.sv
// Generic DEPTH-entry FIFO of any type with synchronous flush; push is ignored
// when full, pop when empty, and flush overrides both.
module ysyx_24080006_fifo #(
   parameter int  DEPTH = 2,
   parameter type T     = logic
) (
   input  logic clock,
   input  logic reset,
   input  logic push,
   input  logic pop,
   input  logic flush,
   input  T     din,
   output T     head,
   output logic full,
   output logic empty
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   T               mem [DEPTH];
   logic [PW-1:0]  rptr;
   logic [PW-1:0]  wptr;
   logic [CW-1:0]  count;
   logic           do_push;
   logic           do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign head    = empty ? '0 : mem[rptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else if (flush) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= next_ptr(wptr);
         if (do_pop)  rptr <= next_ptr(rptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: head is masked to zero while the queue is empty.
   always_ff @(posedge clock) begin
      if (do_push) mem[wptr] <= din;
   end

endmodule

// File: rtl/ysyx_24080006_wbu_q.sv
// Write-back unit: in-order retire queue between LSU and IFU that drives the
// RF and CSR write ports once per retired instruction, plus a retire counter.
module ysyx_24080006_wbu_q
   import ysyx_24080006_pkg::*;
#(
   parameter int          DEPTH       = 2,
   parameter logic [31:0] ECALL_CAUSE = 32'd11,
   parameter int          CNT_W       = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  stage_t           lsu2wbu,
   output logic             wbu2lsu_ready,
   output stage_t           wbu2ifu,
   input  logic             ifu2wbu_ready,
   input  logic             flush,
   output logic [4:0]       rd,
   output logic [31:0]      wdata,
   output logic             we,
   output logic             csr_we,
   output logic [11:0]      csr_waddr,
   output logic [31:0]      csr_wdata,
   output logic [CNT_W-1:0] retire_cnt
);

   wb_entry_t in_entry;
   wb_entry_t head;
   wb_write_t wr_q;
   logic      full;
   logic      empty;
   logic      init_done;
   logic      retire;

   // Ready stays low until the first edge after reset release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) init_done <= 1'b0;
      else        init_done <= 1'b1;
   end

   assign wbu2lsu_ready = init_done && !full;
   assign retire        = !empty && ifu2wbu_ready && !flush;

   always_comb begin
      in_entry           = '0;
      in_entry.wb        = lsu2wbu.wb;
      in_entry.csr_we    = lsu2wbu.csr_we;
      in_entry.ecall     = lsu2wbu.ecall;
      in_entry.rd_addr   = lsu2wbu.rd_addr;
      in_entry.alu_res   = lsu2wbu.alu_res;
      in_entry.csr_wdata = lsu2wbu.csr_wdata;
      in_entry.csr_addr  = lsu2wbu.csr_addr;
      in_entry.dnpc      = lsu2wbu.dnpc;
      in_entry.jump      = lsu2wbu.jump;
      in_entry.branch    = lsu2wbu.branch;
   end

   ysyx_24080006_fifo #(
      .DEPTH (DEPTH),
      .T     (wb_entry_t)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (lsu2wbu.valid && wbu2lsu_ready),
      .pop   (ifu2wbu_ready),
      .flush (flush),
      .din   (in_entry),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      wbu2ifu = '0;
      if (!empty) begin
         wbu2ifu.valid     = 1'b1;
         wbu2ifu.wb        = head.wb;
         wbu2ifu.csr_we    = head.csr_we;
         wbu2ifu.ecall     = head.ecall;
         wbu2ifu.rd_addr   = head.wb ? head.rd_addr : 5'd0;
         wbu2ifu.alu_res   = head.alu_res;
         wbu2ifu.csr_wdata = head.csr_wdata;
         wbu2ifu.csr_addr  = head.csr_addr;
         wbu2ifu.dnpc      = head.dnpc;
         wbu2ifu.jump      = head.jump;
         wbu2ifu.branch    = head.branch;
      end
   end

   // Write ports are single-cycle pulses: cleared in every cycle without a retire.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_q       <= '0;
         retire_cnt <= '0;
      end else if (retire) begin
         wr_q       <= wb_decode(head, ECALL_CAUSE);
         retire_cnt <= retire_cnt + CNT_W'(1);
      end else begin
         wr_q       <= '0;
      end
   end

   assign rd        = wr_q.rd;
   assign wdata     = wr_q.wdata;
   assign we        = wr_q.we;
   assign csr_we    = wr_q.csr_we;
   assign csr_waddr = wr_q.csr_waddr;
   assign csr_wdata = wr_q.csr_wdata;

endmodule

// File: tb/tb_ysyx_24080006_wbu_q.sv
// Directed bench for the write-back retire queue: latency, decode, backpressure,
// flush priority and asynchronous reset, checked against hand-computed values.
module tb_ysyx_24080006_wbu_q;
   import ysyx_24080006_pkg::*;

   logic        clock;
   logic        reset;
   stage_t      lsu2wbu;
   logic        wbu2lsu_ready;
   stage_t      wbu2ifu;
   logic        ifu2wbu_ready;
   logic        flush;
   logic [4:0]  rd;
   logic [31:0] wdata;
   logic        we;
   logic        csr_we;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic [31:0] retire_cnt;

   int compared   = 0;
   int mismatched = 0;

   ysyx_24080006_wbu_q #(.DEPTH(2), .ECALL_CAUSE(32'd11), .CNT_W(32)) dut (
      .clock         (clock),
      .reset         (reset),
      .lsu2wbu       (lsu2wbu),
      .wbu2lsu_ready (wbu2lsu_ready),
      .wbu2ifu       (wbu2ifu),
      .ifu2wbu_ready (ifu2wbu_ready),
      .flush         (flush),
      .rd            (rd),
      .wdata         (wdata),
      .we            (we),
      .csr_we        (csr_we),
      .csr_waddr     (csr_waddr),
      .csr_wdata     (csr_wdata),
      .retire_cnt    (retire_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic stage_t mk(input logic w, input logic c, input logic e, input logic [4:0] r,
                                 input logic [31:0] alu, input logic [31:0] cwd,
                                 input logic [11:0] ca, input logic [31:0] pc);
      stage_t s;
      s = '0;
      s.valid = 1'b1; s.wb = w; s.csr_we = c; s.ecall = e; s.rd_addr = r;
      s.alu_res = alu; s.csr_wdata = cwd; s.csr_addr = ca; s.dnpc = pc;
      return s;
   endfunction

   // Called at a negedge; returns at the negedge after the enqueue edge.
   task automatic push_one(input stage_t s);
      lsu2wbu = s;
      @(negedge clock);
      lsu2wbu = '0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_we"}, 64'(we), 64'd0);
      chk({tag, "_csr_we"}, 64'(csr_we), 64'd0);
   endtask

   initial begin
      reset = 1'b0; lsu2wbu = '0; ifu2wbu_ready = 1'b0; flush = 1'b0;
      #12;
      chk("rst_ready", 64'(wbu2lsu_ready), 64'd0);
      chk("rst_valid", 64'(wbu2ifu.valid), 64'd0);
      chk("rst_payload", 64'(wbu2ifu.dnpc), 64'd0);
      chk("rst_cnt", 64'(retire_cnt), 64'd0);
      chk_quiet("rst");
      @(negedge clock); reset = 1'b1;
      @(negedge clock);
      chk("ready_after_rst", 64'(wbu2lsu_ready), 64'd1);

      // single wb instruction
      ifu2wbu_ready = 1'b1;
      push_one(mk(1, 0, 0, 5'd5, 32'hDEADBEEF, 32'h0, 12'h0, 32'h8000_0004));
      chk("t1_valid", 64'(wbu2ifu.valid), 64'd1);
      chk("t1_ifu_rd", 64'(wbu2ifu.rd_addr), 64'd5);
      chk("t1_dnpc", 64'(wbu2ifu.dnpc), 64'h8000_0004);
      chk("t1_no_early_we", 64'(we), 64'd0);
      @(negedge clock);
      chk("t1_we", 64'(we), 64'd1);
      chk("t1_rd", 64'(rd), 64'd5);
      chk("t1_wdata", 64'(wdata), 64'hDEADBEEF);
      chk("t1_cnt", 64'(retire_cnt), 64'd1);
      chk("t1_valid_gone", 64'(wbu2ifu.valid), 64'd0);
      @(negedge clock);
      chk("t1_we_pulse", 64'(we), 64'd0);

      // csr write instruction
      push_one(mk(0, 1, 0, 5'd3, 32'h8, 32'h1800, 12'h300, 32'h8000_0008));
      chk("t2_ifu_rd_zero", 64'(wbu2ifu.rd_addr), 64'd0);
      @(negedge clock);
      chk("t2_we", 64'(we), 64'd1);
      chk("t2_rd", 64'(rd), 64'd3);
      chk("t2_wdata", 64'(wdata), 64'h1800);
      chk("t2_csr_we", 64'(csr_we), 64'd1);
      chk("t2_csr_waddr", 64'(csr_waddr), 64'h300);
      chk("t2_csr_wdata", 64'(csr_wdata), 64'h8);
      chk("t2_cnt", 64'(retire_cnt), 64'd2);

      // ecall, then wb to x0
      push_one(mk(0, 0, 1, 5'd0, 32'h0, 32'h0, 12'h0, 32'h8000_000c));
      @(negedge clock);
      chk("t3_csr_we", 64'(csr_we), 64'd1);
      chk("t3_csr_waddr", 64'(csr_waddr), 64'h342);
      chk("t3_csr_wdata", 64'(csr_wdata), 64'd11);
      chk("t3_we", 64'(we), 64'd0);
      push_one(mk(1, 0, 0, 5'd0, 32'h1234, 32'h0, 12'h0, 32'h8000_0010));
      @(negedge clock);
      chk("t3_x0_we", 64'(we), 64'd0);
      chk("t3_x0_rd", 64'(rd), 64'd0);
      chk("t3_x0_wdata", 64'(wdata), 64'd0);
      chk("t3_x0_cnt", 64'(retire_cnt), 64'd4);

      // backpressure: three back-to-back pushes into a 2-deep queue
      ifu2wbu_ready = 1'b0;
      lsu2wbu = mk(1, 0, 0, 5'd1, 32'h111, 32'h0, 12'h0, 32'hA0);
      @(negedge clock);
      chk("t4_ready_1", 64'(wbu2lsu_ready), 64'd1);
      lsu2wbu = mk(1, 0, 0, 5'd2, 32'h222, 32'h0, 12'h0, 32'hB0);
      @(negedge clock);
      chk("t4_ready_full", 64'(wbu2lsu_ready), 64'd0);
      lsu2wbu = mk(1, 0, 0, 5'd7, 32'h333, 32'h0, 12'h0, 32'hC0);
      @(negedge clock);
      chk("t4_stall_ready", 64'(wbu2lsu_ready), 64'd0);
      chk("t4_stall_dnpc", 64'(wbu2ifu.dnpc), 64'hA0);
      chk("t4_stall_rd", 64'(wbu2ifu.rd_addr), 64'd1);
      chk_quiet("t4_stall");
      ifu2wbu_ready = 1'b1;
      @(negedge clock);
      chk("t4_r1_wdata", 64'(wdata), 64'h111);
      chk("t4_r1_we", 64'(we), 64'd1);
      chk("t4_r1_head", 64'(wbu2ifu.dnpc), 64'hB0);
      chk("t4_r1_ready", 64'(wbu2lsu_ready), 64'd1);
      @(negedge clock);
      lsu2wbu = '0;
      chk("t4_r2_wdata", 64'(wdata), 64'h222);
      chk("t4_r2_rd", 64'(rd), 64'd2);
      chk("t4_r2_head", 64'(wbu2ifu.dnpc), 64'hC0);
      @(negedge clock);
      chk("t4_r3_wdata", 64'(wdata), 64'h333);
      chk("t4_r3_rd", 64'(rd), 64'd7);
      chk("t4_r3_valid", 64'(wbu2ifu.valid), 64'd0);
      chk("t4_cnt", 64'(retire_cnt), 64'd7);

      // flush with simultaneous enqueue and dequeue
      ifu2wbu_ready = 1'b0;
      push_one(mk(1, 0, 0, 5'd4, 32'h444, 32'h0, 12'h0, 32'hD0));
      push_one(mk(0, 1, 0, 5'd6, 32'h555, 32'h9, 12'h305, 32'hE0));
      chk("t5_full", 64'(wbu2lsu_ready), 64'd0);
      flush = 1'b1; ifu2wbu_ready = 1'b1;
      lsu2wbu = mk(1, 0, 0, 5'd8, 32'h666, 32'h0, 12'h0, 32'hF0);
      @(negedge clock);
      flush = 1'b0; lsu2wbu = '0;
      chk("t5_valid", 64'(wbu2ifu.valid), 64'd0);
      chk_quiet("t5_flush");
      chk("t5_cnt", 64'(retire_cnt), 64'd7);
      chk("t5_ready", 64'(wbu2lsu_ready), 64'd1);
      @(negedge clock);
      chk("t5_no_enq", 64'(wbu2ifu.valid), 64'd0);
      chk_quiet("t5_after");

      // asynchronous reset with a full, stalled queue
      ifu2wbu_ready = 1'b0;
      push_one(mk(1, 0, 0, 5'd10, 32'h777, 32'h0, 12'h0, 32'h100));
      push_one(mk(1, 0, 0, 5'd11, 32'h888, 32'h0, 12'h0, 32'h104));
      chk("t6_full", 64'(wbu2lsu_ready), 64'd0);
      #2 reset = 1'b0;
      #1;
      chk("t6_valid", 64'(wbu2ifu.valid), 64'd0);
      chk("t6_ready", 64'(wbu2lsu_ready), 64'd0);
      chk("t6_dnpc", 64'(wbu2ifu.dnpc), 64'd0);
      chk("t6_cnt", 64'(retire_cnt), 64'd0);
      chk_quiet("t6_rst");
      @(negedge clock); reset = 1'b1;
      @(negedge clock);
      chk("t6_ready_rel", 64'(wbu2lsu_ready), 64'd1);
      ifu2wbu_ready = 1'b1;
      push_one(mk(1, 0, 0, 5'd9, 32'h55, 32'h0, 12'h0, 32'h200));
      chk("t6_new_valid", 64'(wbu2ifu.valid), 64'd1);
      @(negedge clock);
      chk("t6_new_we", 64'(we), 64'd1);
      chk("t6_new_rd", 64'(rd), 64'd9);
      chk("t6_new_wdata", 64'(wdata), 64'h55);
      chk("t6_new_cnt", 64'(retire_cnt), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
